// File: rtl/ifetch_queue.sv
// Instruction fetch unit: owns the fetch PC, requests one word at a time from
// memory and buffers fetched instructions in a small circular queue for the decoder.
module ifetch_queue #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] PC,
  output logic        ask_for,
  input  logic        give_you,
  input  logic [31:0] give_you_ins,
  output logic        is_ins,
  output logic [31:0] ins,
  output logic [31:0] ins_addr,
  output logic        ins_is_c,
  input  logic        dc_stuck,
  input  logic        dc_clear,
  input  logic [31:0] dc_new_pc,
  input  logic        rob_clear,
  input  logic [31:0] new_pc
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        pc_reg, pc_next;
  logic [CNT_W-1:0]   count_reg, count_next, count_calc;
  logic [PTR_W-1:0]   head_reg, tail_reg;

  logic [31:0]            addr_mem [QUEUE_DEPTH];
  logic [31:0]            data_mem [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] c_mem;

  logic        redirect;
  logic [31:0] target;
  logic        is_c;
  logic [31:0] ins_word;
  logic        push;
  logic        pop;
  logic        room;

  always_comb begin
    redirect   = rob_clear | dc_clear;
    target     = (rob_clear ? new_pc : dc_new_pc) & 32'hFFFF_FFFE;
    is_c       = (give_you_ins[1:0] != 2'b11);
    ins_word   = is_c ? {16'h0000, give_you_ins[15:0]} : give_you_ins;
    push       = (state_reg == REQ) && give_you && !redirect;
    pop        = is_ins && !dc_stuck && !redirect;
    count_calc = count_reg + CNT_W'(push) - CNT_W'(pop);
    room       = (count_calc < DEPTH_C);
    count_next = redirect ? '0 : count_calc;
  end

  // Next-state and PC update; a redirect always wins over a same-cycle response.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      IDLE: begin
        if (redirect) begin
          state_next = REQ;
          pc_next    = target;
        end else if (room) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          pc_next    = target;
          state_next = give_you ? REQ : DISCARD;
        end else if (give_you) begin
          pc_next    = pc_reg + (is_c ? 32'd2 : 32'd4);
          state_next = room ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (redirect) pc_next = target;
        if (give_you) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else if (rdy_in) begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;
      if (redirect) begin
        head_reg <= '0;
        tail_reg <= '0;
      end else begin
        head_reg <= head_reg + PTR_W'(pop);
        tail_reg <= tail_reg + PTR_W'(push);
      end
    end
  end

  // Entries are cleared on reset so the head outputs read as zero afterwards.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
      c_mem <= '0;
    end else if (rdy_in && push) begin
      addr_mem[tail_reg] <= pc_reg;
      data_mem[tail_reg] <= ins_word;
      c_mem[tail_reg]    <= is_c;
    end
  end

  assign PC       = pc_reg;
  assign ask_for  = (state_reg == REQ) || (state_reg == DISCARD);
  assign is_ins   = (count_reg != '0);
  assign ins      = data_mem[head_reg];
  assign ins_addr = addr_mem[head_reg];
  assign ins_is_c = c_mem[head_reg];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: scenario tasks drive stimulus and compare
// the DUT outputs with hand-computed values.
module tb_ifetch_queue;

  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] PC;
  logic        ask_for;
  logic        give_you;
  logic [31:0] give_you_ins;
  logic        is_ins;
  logic [31:0] ins;
  logic [31:0] ins_addr;
  logic        ins_is_c;
  logic        dc_stuck;
  logic        dc_clear;
  logic [31:0] dc_new_pc;
  logic        rob_clear;
  logic [31:0] new_pc;

  int compared = 0;
  int mismatched = 0;

  ifetch_queue #(.QUEUE_DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .PC(PC), .ask_for(ask_for),
    .give_you(give_you), .give_you_ins(give_you_ins),
    .is_ins(is_ins), .ins(ins), .ins_addr(ins_addr), .ins_is_c(ins_is_c),
    .dc_stuck(dc_stuck), .dc_clear(dc_clear), .dc_new_pc(dc_new_pc),
    .rob_clear(rob_clear), .new_pc(new_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    step();
    step();
    compared++; if (PC !== 32'h100) begin mismatched++; $display("FAIL reset_pc: got %h want %h", PC, 32'h100); end
    compared++; if (ask_for !== 1'b0) begin mismatched++; $display("FAIL reset_ask: got %b want 0", ask_for); end
    compared++; if (is_ins !== 1'b0) begin mismatched++; $display("FAIL reset_is_ins: got %b want 0", is_ins); end
    compared++; if (ins !== 32'h0) begin mismatched++; $display("FAIL reset_ins: got %h want 0", ins); end
    compared++; if (ins_addr !== 32'h0) begin mismatched++; $display("FAIL reset_ins_addr: got %h want 0", ins_addr); end
    compared++; if (ins_is_c !== 1'b0) begin mismatched++; $display("FAIL reset_ins_is_c: got %b want 0", ins_is_c); end
    rst_in = 1'b1;
    compared++; if (ask_for !== 1'b0) begin mismatched++; $display("FAIL release_ask_first: got %b want 0", ask_for); end
    step();
    compared++; if (ask_for !== 1'b1) begin mismatched++; $display("FAIL release_ask_second: got %b want 1", ask_for); end
    $display("reset: PC=%h ask_for=%b", PC, ask_for);
  endtask

  task automatic test_sequential();
    dc_stuck = 1'b1;
    give_you = 1'b1; give_you_ins = 32'h0000_0013;
    step();
    compared++; if (is_ins !== 1'b1) begin mismatched++; $display("FAIL seq_is_ins: got %b want 1", is_ins); end
    compared++; if (ins !== 32'h13) begin mismatched++; $display("FAIL seq_ins0: got %h want 00000013", ins); end
    compared++; if (ins_addr !== 32'h100) begin mismatched++; $display("FAIL seq_addr0: got %h want 00000100", ins_addr); end
    compared++; if (ins_is_c !== 1'b0) begin mismatched++; $display("FAIL seq_c0: got %b want 0", ins_is_c); end
    compared++; if (PC !== 32'h104) begin mismatched++; $display("FAIL seq_pc0: got %h want 00000104", PC); end
    compared++; if (ask_for !== 1'b1) begin mismatched++; $display("FAIL seq_ask: got %b want 1", ask_for); end
    $display("push: addr=%h ins=%h c=%b", ins_addr, ins, ins_is_c);
    give_you_ins = 32'hABCD_4501;
    step();
    compared++; if (PC !== 32'h106) begin mismatched++; $display("FAIL seq_pc1: got %h want 00000106", PC); end
    compared++; if (ins_addr !== 32'h100) begin mismatched++; $display("FAIL seq_stuck_head: got %h want 00000100", ins_addr); end
    give_you = 1'b0; dc_stuck = 1'b0;
    step();
    compared++; if (ins !== 32'h0000_4501) begin mismatched++; $display("FAIL seq_ins1: got %h want 00004501", ins); end
    compared++; if (ins_addr !== 32'h104) begin mismatched++; $display("FAIL seq_addr1: got %h want 00000104", ins_addr); end
    compared++; if (ins_is_c !== 1'b1) begin mismatched++; $display("FAIL seq_c1: got %b want 1", ins_is_c); end
    $display("pop: next head addr=%h ins=%h c=%b", ins_addr, ins, ins_is_c);
    step();
    compared++; if (is_ins !== 1'b0) begin mismatched++; $display("FAIL seq_empty: got %b want 0", is_ins); end
  endtask

  task automatic test_fill_backpressure();
    int n = 0;
    logic [31:0] exp_addr;
    dc_stuck = 1'b1;
    give_you_ins = 32'h0000_0013;
    for (int c = 0; c < 10 && ask_for; c++) begin
      give_you = 1'b1;
      n++;
      step();
    end
    give_you = 1'b0;
    compared++; if (n !== 4) begin mismatched++; $display("FAIL fill_pushes: got %0d want 4", n); end
    compared++; if (ask_for !== 1'b0) begin mismatched++; $display("FAIL fill_ask_low: got %b want 0", ask_for); end
    compared++; if (PC !== 32'h116) begin mismatched++; $display("FAIL fill_pc: got %h want 00000116", PC); end
    step();
    compared++; if (ask_for !== 1'b0) begin mismatched++; $display("FAIL fill_idle_hold: got %b want 0", ask_for); end
    compared++; if (ins_addr !== 32'h106) begin mismatched++; $display("FAIL fill_head: got %h want 00000106", ins_addr); end
    $display("fill: %0d pushes, ask_for=%b", n, ask_for);
    dc_stuck = 1'b0;
    step();
    compared++; if (ask_for !== 1'b1) begin mismatched++; $display("FAIL drain_ask_reassert: got %b want 1", ask_for); end
    exp_addr = 32'h10A;
    for (int k = 0; k < 3; k++) begin
      compared++; if (ins_addr !== exp_addr || is_ins !== 1'b1) begin mismatched++; $display("FAIL drain_head%0d: got %h/%b want %h/1", k, ins_addr, is_ins, exp_addr); end
      $display("pop: addr=%h", ins_addr);
      exp_addr = exp_addr + 32'd4;
      step();
    end
    compared++; if (is_ins !== 1'b0) begin mismatched++; $display("FAIL drain_empty: got %b want 0", is_ins); end
  endtask

  task automatic test_redirect_outstanding();
    dc_clear = 1'b1; dc_new_pc = 32'h2001;
    step();
    dc_clear = 1'b0;
    compared++; if (PC !== 32'h2000) begin mismatched++; $display("FAIL redir_pc: got %h want 00002000", PC); end
    compared++; if (is_ins !== 1'b0) begin mismatched++; $display("FAIL redir_empty: got %b want 0", is_ins); end
    compared++; if (ask_for !== 1'b1) begin mismatched++; $display("FAIL redir_ask: got %b want 1", ask_for); end
    give_you = 1'b1; give_you_ins = 32'h1111_1111;
    step();
    compared++; if (is_ins !== 1'b0) begin mismatched++; $display("FAIL redir_drop: got %b want 0", is_ins); end
    compared++; if (PC !== 32'h2000) begin mismatched++; $display("FAIL redir_pc_hold: got %h want 00002000", PC); end
    give_you_ins = 32'h2222_2223;
    step();
    give_you = 1'b0;
    compared++; if (is_ins !== 1'b1 || ins_addr !== 32'h2000) begin mismatched++; $display("FAIL redir_push: got %b/%h want 1/00002000", is_ins, ins_addr); end
    compared++; if (ins !== 32'h2222_2223) begin mismatched++; $display("FAIL redir_ins: got %h want 22222223", ins); end
    compared++; if (PC !== 32'h2004) begin mismatched++; $display("FAIL redir_pc_next: got %h want 00002004", PC); end
    $display("redirect: dropped stale, pushed addr=%h", ins_addr);
  endtask

  task automatic test_simultaneous();
    dc_stuck = 1'b1;
    rob_clear = 1'b1; new_pc = 32'h300;
    dc_clear = 1'b1; dc_new_pc = 32'h400;
    give_you = 1'b1; give_you_ins = 32'h3333_3333;
    step();
    rob_clear = 1'b0; dc_clear = 1'b0;
    compared++; if (PC !== 32'h300) begin mismatched++; $display("FAIL simul_pc: got %h want 00000300", PC); end
    compared++; if (is_ins !== 1'b0) begin mismatched++; $display("FAIL simul_flush: got %b want 0", is_ins); end
    compared++; if (ask_for !== 1'b1) begin mismatched++; $display("FAIL simul_ask: got %b want 1", ask_for); end
    give_you_ins = 32'h0000_0513;
    step();
    give_you = 1'b0;
    compared++; if (is_ins !== 1'b1 || ins_addr !== 32'h300) begin mismatched++; $display("FAIL simul_req: got %b/%h want 1/00000300", is_ins, ins_addr); end
    compared++; if (PC !== 32'h304) begin mismatched++; $display("FAIL simul_pc_next: got %h want 00000304", PC); end
    $display("simultaneous: PC=%h head=%h", PC, ins_addr);
  endtask

  task automatic test_freeze_reset();
    give_you = 1'b1; give_you_ins = 32'h0000_0001;
    step();
    rdy_in = 1'b0;
    give_you_ins = 32'h0000_0099; dc_stuck = 1'b0;
    dc_clear = 1'b1; dc_new_pc = 32'h5000;
    for (int k = 0; k < 3; k++) begin
      step();
      compared++; if (PC !== 32'h306) begin mismatched++; $display("FAIL freeze_pc%0d: got %h want 00000306", k, PC); end
      compared++; if (is_ins !== 1'b1 || ins_addr !== 32'h300 || ins !== 32'h513 || ins_is_c !== 1'b0) begin
        mismatched++; $display("FAIL freeze_head%0d: got %b/%h/%h/%b want 1/00000300/00000513/0", k, is_ins, ins_addr, ins, ins_is_c);
      end
      compared++; if (ask_for !== 1'b1) begin mismatched++; $display("FAIL freeze_ask%0d: got %b want 1", k, ask_for); end
      $display("freeze cycle %0d: PC=%h", k, PC);
    end
    rdy_in = 1'b1; dc_clear = 1'b0;
    give_you = 1'b1; give_you_ins = 32'h0000_0013;
    step();
    give_you = 1'b0; dc_stuck = 1'b1;
    compared++; if (ins_addr !== 32'h304 || ins !== 32'h1 || ins_is_c !== 1'b1) begin
      mismatched++; $display("FAIL thaw_head: got %h/%h/%b want 00000304/00000001/1", ins_addr, ins, ins_is_c);
    end
    compared++; if (PC !== 32'h30A) begin mismatched++; $display("FAIL thaw_pc: got %h want 0000030a", PC); end
    rst_in = 1'b0;
    step();
    compared++; if (is_ins !== 1'b0) begin mismatched++; $display("FAIL midreset_is_ins: got %b want 0", is_ins); end
    compared++; if (PC !== 32'h100) begin mismatched++; $display("FAIL midreset_pc: got %h want 00000100", PC); end
    compared++; if (ask_for !== 1'b0) begin mismatched++; $display("FAIL midreset_ask: got %b want 0", ask_for); end
    $display("mid-stream reset: PC=%h is_ins=%b", PC, is_ins);
    rst_in = 1'b1;
    step();
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1;
    give_you = 1'b0; give_you_ins = 32'h0;
    dc_stuck = 1'b0; dc_clear = 1'b0; dc_new_pc = 32'h0;
    rob_clear = 1'b0; new_pc = 32'h0;
    #1;
    test_reset();
    test_sequential();
    test_fill_backpressure();
    test_redirect_outstanding();
    test_simultaneous();
    test_freeze_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction fetch unit with a decoupling instruction queue. It sits between the memory/icache manager and the decoder, and owns the architectural fetch PC. Each completed fetch is checked for a compressed (16-bit) or full (32-bit) RV instruction, and the PC advances by 2 or 4 accordingly. Instructions are buffered so the decoder can stall without stalling memory. ROB and decoder redirects flush the queue, and any response already in flight is discarded.

## Interface
- QUEUE_DEPTH, 4: queue entries; a power of two, at least 2.
- RESET_PC, 32'h0: PC value after reset.
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  reset, synchronous, active-low.
- rdy_in  input  1  global enable; when low, all state is frozen.
- PC  output  32  current fetch PC; it is also the fetch address and is always halfword-aligned.
- ask_for  output  1  a fetch of the word at PC is outstanding.
- give_you  input  1  one-cycle pulse; the fetch completes.
- give_you_ins  input  32  fetched bits; the instruction starts at bit 0.
- is_ins  output  1  the queue head is valid.
- ins  output  32  head instruction; a compressed instruction is zero-extended from bits [15:0].
- ins_addr  output  32  address of the head instruction.
- ins_is_c  output  1  the head instruction is compressed.
- dc_stuck  input  1  the decoder refuses the head this cycle.
- dc_clear  input  1  decoder redirect to dc_new_pc.
- dc_new_pc  input  32  decoder redirect target.
- rob_clear  input  1  ROB redirect to new_pc; takes priority over dc_clear.
- new_pc  input  32  ROB redirect target.

## Operation
- **Redirect.** redirect = rob_clear | dc_clear; target = rob_clear ? new_pc : dc_new_pc, with bit 0 forced to 0.
- **FSM states.** IDLE, REQ, DISCARD. ask_for = (state == REQ) | (state == DISCARD).
- **Room.** count_next = count + push - pop. room = count_next < QUEUE_DEPTH.
- **IDLE:**
  - on redirect: go to REQ.
  - otherwise, if room: go to REQ.
- **REQ, redirect without give_you:** go to DISCARD, PC <= target, flush the queue.
- **REQ, redirect with give_you in the same cycle:** drop the response, PC <= target, flush, stay in REQ.
- **REQ, give_you without redirect:**
  - push {PC, instruction, is_c}.
  - PC <= PC + (is_c ? 2 : 4), computed modulo 2^32.
  - stay in REQ if room, else go to IDLE.
- **DISCARD:**
  - on give_you: drop the response and go to REQ.
  - on redirect: PC <= target and stay in DISCARD, or go to REQ if give_you arrives in the same cycle.
- **Compressed detect.** is_c = (give_you_ins[1:0] != 2'b11).
- **Pop.** Occurs when is_ins & !dc_stuck & !redirect. A redirect flushes the queue in the same cycle and overrides both push and pop.
- **Full queue.** No request is issued while count == QUEUE_DEPTH, so a push never meets a full queue without a simultaneous pop.
- **Memory contract.** The address is held while ask_for is high; the memory side must return exactly one give_you per request.
- **rdy_in low.** No state changes and inputs are ignored; callers hold any pending give_you until rdy_in is high.

## Timing
- **Reset (rst_in low at an edge):**
  - PC = RESET_PC, state = IDLE, count = 0.
  - ask_for = 0, is_ins = 0, ins = 0, ins_addr = 0, ins_is_c = 0.
- **After reset release:** ask_for = 0 in the first cycle and rises in the second cycle.
- **Fetch latency:** give_you in cycle T puts is_ins high in T+1 (empty queue case) with that instruction at the head. The next PC is visible in T+1, and ask_for stays high if there was room.
- **Throughput:** one instruction per cycle when memory answers every cycle and the decoder never stalls.
- **Queue head outputs:** driven directly from the head storage registers, with no extra output register.
- **Redirect in cycle T:**
  - is_ins = 0 in T+1 and PC = target in T+1.
  - The first new instruction appears no earlier than T+2, or after the stale response has been dropped.
- **Reset mid-fetch:** the outstanding request is abandoned. The memory side is reset on the same rst_in, so no stale give_you follows.

## Test plan
- **Sequential fetch.** RESET_PC = 0x100; memory returns 0x00000013 (4-byte) then 0x00004501 (compressed).
  - Entries {0x100, 0x00000013, c=0} then {0x104, 0x00004501, c=1}.
  - PC then equals 0x106.
- **Fill and backpressure.** Hold dc_stuck = 1 with QUEUE_DEPTH = 4 and memory answering every cycle.
  - Exactly 4 pushes occur, then ask_for = 0 and the FSM sits in IDLE.
  - Releasing dc_stuck pops one entry per cycle, and ask_for reasserts on the cycle after the first pop.
- **Redirect while outstanding.** dc_clear with dc_new_pc = 0x2001 while ask_for = 1 and no give_you.
  - PC = 0x2000 next cycle and the queue is empty.
  - The next give_you (ins 0x11111111) is dropped; the following one is pushed with address 0x2000.
- **Simultaneous redirect and give_you.** rob_clear with new_pc = 0x300, together with dc_clear with dc_new_pc = 0x400, in the same cycle as give_you.
  - The response is dropped, PC = 0x300, and the FSM stays in REQ.
- **Freeze and reset.** Drop rdy_in for 3 cycles mid-stream: PC, count and all outputs are unchanged.
  - Then assert rst_in = 0 with the queue holding 2 entries: next cycle is_ins = 0 and PC = RESET_PC.
